// File: rtl/fifo_serializer_if.sv
// FIFO read port, enable and serial-line signals of fifo_serializer.
// The slave side is the serializer; the master side drives it.
interface fifo_serializer_if #(
  parameter int WIDTH = 4
);
  logic             tx_enable;
  logic             fifo_empty;
  logic [0:WIDTH-1] fifo_data;
  logic             fifo_rd_en;
  logic             ser_out;
  logic             ser_frame;
  logic             busy;
  logic [15:0]      frame_count;

  modport slave (
    input  tx_enable,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output ser_out,
    output ser_frame,
    output busy,
    output frame_count
  );

  modport master (
    output tx_enable,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  ser_out,
    input  ser_frame,
    input  busy,
    input  frame_count
  );
endinterface

// File: rtl/fifo_serializer.sv
// FIFO drain stage: pops words and sends start/data/[parity]/stop frames.
// Optional even-parity bit enabled by macro FIFO_SERIALIZER_PARITY_EN.
module fifo_serializer #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1
) (
  input logic               clk,
  input logic               rstn,
  fifo_serializer_if.slave  bus
);
  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CYC_LAST =
    CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
`ifdef FIFO_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP,
    GAP
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cyc_q, cyc_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [GW-1:0]    gap_q, gap_n;
  logic [0:WIDTH-1] sh_q, sh_n;
  logic             ser_q, ser_n;
  logic             frame_q, frame_n;
  logic             busy_q, busy_n;
  logic [15:0]      fc_q;
  logic             bit_done;
  logic             pop;

  assign bit_done = (cyc_q == CYC_LAST);

  // Gated by rstn so no pop can escape while reset is held.
  assign pop = rstn && (state_q == IDLE) &&
               bus.tx_enable && !bus.fifo_empty;

  assign bus.fifo_rd_en  = pop;
  assign bus.ser_out     = ser_q;
  assign bus.ser_frame   = frame_q;
  assign bus.busy        = busy_q;
  assign bus.frame_count = fc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pop) state_n = WAIT;
      end
      (state_q == WAIT): begin
        state_n = START;
      end
      (state_q == START): begin
        if (bit_done) state_n = DATA;
      end
      (state_q == DATA): begin
        if (bit_done && idx_q == IDX_LAST) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef FIFO_SERIALIZER_PARITY_EN
      (state_q == PARITY): begin
        if (bit_done) state_n = STOP;
      end
`endif
      (state_q == STOP): begin
        if (bit_done)
          state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      (state_q == GAP): begin
        if (gap_q == GAP_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters restart on every state change.
  always_comb begin
    cyc_n = '0;
    idx_n = '0;
    gap_n = '0;
    sh_n  = sh_q;
    if (state_n == state_q) begin
      cyc_n = bit_done ? '0 : cyc_q + 1'b1;
      idx_n = idx_q;
      if (state_q == DATA && bit_done)
        idx_n = idx_q + 1'b1;
      if (state_q == GAP)
        gap_n = gap_q + 1'b1;
    end
    if (state_q == WAIT) begin
      sh_n = bus.fifo_data;
    end else if (state_q == DATA && state_n == DATA &&
                 bit_done) begin
      // Rotate so the word stays intact for parity.
      sh_n = {sh_q[1:WIDTH-1], sh_q[0]};
    end
  end

  // Line outputs are registered from the next state.
  always_comb begin
    ser_n   = 1'b1;
    frame_n = 1'b0;
    busy_n  = (state_n != IDLE);
    unique case (1'b1)
      (state_n == START): begin
        ser_n   = 1'b0;
        frame_n = 1'b1;
      end
      (state_n == DATA): begin
        ser_n   = sh_n[0];
        frame_n = 1'b1;
      end
`ifdef FIFO_SERIALIZER_PARITY_EN
      (state_n == PARITY): begin
        ser_n   = ^sh_n;
        frame_n = 1'b1;
      end
`endif
      (state_n == STOP): begin
        frame_n = 1'b1;
      end
      default: begin
        ser_n   = 1'b1;
        frame_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      ser_q   <= 1'b1;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      cyc_q   <= cyc_n;
      idx_q   <= idx_n;
      gap_q   <= gap_n;
      sh_q    <= sh_n;
      ser_q   <= ser_n;
      frame_q <= frame_n;
      busy_q  <= busy_n;
      if (state_q == STOP && bit_done)
        fc_q <= fc_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: default instance and a BIT_CYCLES=3,
// GAP_CYCLES=0 instance, each fed from a small FIFO model.
module tb_fifo_serializer;
  localparam int W = 4;
`ifdef FIFO_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_serializer_if #(.WIDTH(W)) b0 ();
  fifo_serializer_if #(.WIDTH(W)) b1 ();

  fifo_serializer #(
    .WIDTH(W), .BIT_CYCLES(1), .GAP_CYCLES(1)
  ) dut0 (.clk(clk), .rstn(rstn), .bus(b0.slave));

  fifo_serializer #(
    .WIDTH(W), .BIT_CYCLES(3), .GAP_CYCLES(0)
  ) dut1 (.clk(clk), .rstn(rstn), .bus(b1.slave));

  logic [W-1:0] mem0 [256];
  logic [W-1:0] mem1 [256];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

  assign b0.fifo_empty = (wp0 == rp0);
  assign b1.fifo_empty = (wp1 == rp1);

  always @(posedge clk) begin
    if (b0.fifo_rd_en) begin
      b0.fifo_data <= mem0[rp0[7:0]];
      rp0 <= rp0 + 1;
    end
    if (b1.fifo_rd_en) begin
      b1.fifo_data <= mem1[rp1[7:0]];
      rp1 <= rp1 + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int fcm [2];

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // {rd_en, busy, ser_frame, ser_out, frame_count}
  function automatic logic [19:0] outs(input int s);
    if (s == 1)
      return {b1.fifo_rd_en, b1.busy, b1.ser_frame,
              b1.ser_out, b1.frame_count};
    return {b0.fifo_rd_en, b0.busy, b0.ser_frame,
            b0.ser_out, b0.frame_count};
  endfunction

  task automatic push(input int s, input logic [W-1:0] w);
    if (s == 1) begin
      mem1[wp1[7:0]] = w;
      wp1 = wp1 + 1;
    end else begin
      mem0[wp0[7:0]] = w;
      wp0 = wp0 + 1;
    end
  endtask

  task automatic set_tx(input int s, input logic v);
    if (s == 1) b1.tx_enable = v;
    else b0.tx_enable = v;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pop(input int s);
    int t;
    t = 0;
    while (outs(s)[19] !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    chk("pop_seen", 16'(outs(s)[19]), 16'd1);
  endtask

  // Follows one frame from its pop cycle T to T+2+F+GAP.
  task automatic run_frame(input int s,
                           input logic [W-1:0] w,
                           input logic more,
                           input int drop_at);
    int bc, gp, f, n;
    logic q[$];
    logic [19:0] o;
    bc = (s == 1) ? 3 : 1;
    gp = (s == 1) ? 0 : 1;
    f  = (2 + W + P) * bc;
    for (int i = 0; i < bc; i++) q.push_back(1'b0);
    for (int k = 0; k < W; k++)
      for (int i = 0; i < bc; i++)
        q.push_back(1'((int'(w) >> (W - 1 - k)) & 1));
    if (P == 1)
      for (int i = 0; i < bc; i++)
        q.push_back(1'($countones(w) & 1));
    for (int i = 0; i < bc; i++) q.push_back(1'b1);
    #1;
    wait_pop(s);
    if (outs(s)[19] !== 1'b1) return;
    n = fcm[s];
    for (int c = 1; c <= 2 + f + gp; c++) begin
      step();
      o = outs(s);
      if (c == 2 + f + gp) begin
        chk("next_pop", 16'(o[19]), 16'(more));
        chk("idle_busy", 16'(o[18]), 16'd0);
      end else begin
        chk("rd_mid", 16'(o[19]), 16'd0);
        chk("busy_mid", 16'(o[18]), 16'd1);
        if (c >= 2 && c <= 1 + f) begin
          chk("ser_bit", 16'(o[16]), 16'(q[c-2]));
          chk("frame_hi", 16'(o[17]), 16'd1);
        end else begin
          chk("ser_idle", 16'(o[16]), 16'd1);
          chk("frame_lo", 16'(o[17]), 16'd0);
        end
      end
      if (c == 1 + f)
        chk("fc_before", o[15:0], 16'(n));
      if (c == 2 + f)
        chk("fc_after", o[15:0], 16'(n + 1));
      if (c == drop_at) set_tx(s, 1'b0);
    end
    fcm[s] = n + 1;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W-1:0] rw [6];
    logic [19:0] o;
    fcm[0] = 0;
    fcm[1] = 0;
    b0.tx_enable = 1'b1;
    b1.tx_enable = 1'b1;
    rstn = 1'b0;
    repeat (2) step();
    o = outs(0);
    chk("rst_ser", 16'(o[16]), 16'd1);
    chk("rst_busy", 16'(o[18]), 16'd0);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      o = outs(0);
      chk("idle_ser", 16'(o[16]), 16'd1);
      chk("idle_frame", 16'(o[17]), 16'd0);
      chk("idle_busy0", 16'(o[18]), 16'd0);
      chk("idle_rd", 16'(o[19]), 16'd0);
      chk("idle_fc", o[15:0], 16'd0);
    end
    o = outs(1);
    chk("idle1_ser", 16'(o[16]), 16'd1);
    chk("idle1_busy", 16'(o[18]), 16'd0);

    push(0, 4'b1010);
    run_frame(0, 4'b1010, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      rw[i] = W'($urandom_range(0, 15));
      push(0, rw[i]);
    end
    for (int i = 0; i < 6; i++)
      run_frame(0, rw[i], 1'(i < 5), -1);

    push(1, 4'b1111);
    push(1, 4'b0001);
    run_frame(1, 4'b1111, 1'b1, -1);
    run_frame(1, 4'b0001, 1'b0, -1);

    a = W'($urandom_range(0, 15));
    b = W'($urandom_range(0, 15));
    push(0, a);
    push(0, b);
    run_frame(0, a, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rd", 16'(outs(0)[19]), 16'd0);
    end
    set_tx(0, 1'b1);
    #1;
    chk("resume_rd", 16'(outs(0)[19]), 16'd1);
    run_frame(0, b, 1'b0, -1);

    a = W'($urandom_range(0, 15));
    b = W'($urandom_range(0, 15));
    push(0, a);
    push(0, b);
    #1;
    wait_pop(0);
    repeat (5) step();
    rstn = 1'b0;
    #1;
    o = outs(0);
    chk("rst_mid_ser", 16'(o[16]), 16'd1);
    chk("rst_mid_busy", 16'(o[18]), 16'd0);
    chk("rst_mid_rd", 16'(o[19]), 16'd0);
    chk("rst_mid_fc", o[15:0], 16'd0);
    chk("rst_mid_frame", 16'(o[17]), 16'd0);
    fcm[0] = 0;
    fcm[1] = 0;
    step();
    rstn = 1'b1;
    run_frame(0, b, 1'b0, -1);
    chk("fc_post_rst", outs(0)[15:0], 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
